// File: rtl/fb_paint_pkg.sv
// Shared constants, FSM encoding and cell addressing for the paint framebuffer.
package fb_paint_pkg;

  localparam int RES_H_DEF = 640;
  localparam int RES_V_DEF = 480;
  localparam int SCALE_DEF = 2;

  localparam int CELLS_H = RES_H_DEF >> SCALE_DEF;
  localparam int CELLS_V = RES_V_DEF >> SCALE_DEF;
  localparam int DEPTH   = CELLS_H * CELLS_V;
  localparam int ADDR_W  = $clog2(DEPTH);

  typedef enum logic [1:0] {CLEAR, IDLE, STAMP} state_t;

  // Row-major cell index; callers pass coordinates already divided down to cells.
  function automatic int unsigned cell_addr(input int unsigned cx, input int unsigned cy,
                                            input int unsigned cells_h);
    return cy * cells_h + cx;
  endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port colour store: one write and one registered read per cycle, no reset.
module fb_ram #(
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [2:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [2:0]        rdata
);

  logic [2:0] mem [DEPTH];

  // Read and write share one process so a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fb_paint_store.sv
// Downscaled 3-bit framebuffer: scan-side registered read, plus clear and brush-stamp write engines.
module fb_paint_store
  import fb_paint_pkg::*;
#(
  parameter int         RESOLUTION_H = 640,
  parameter int         RESOLUTION_V = 480,
  parameter int         HPOS_WIDTH   = 10,
  parameter int         VPOS_WIDTH   = 10,
  parameter int         SCALE_SHIFT  = 2,
  parameter int         BRUSH_SIZE   = 20,
  parameter logic [2:0] CLEAR_COLOR  = 3'b000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [HPOS_WIDTH-1:0] hpos,
  input  logic [VPOS_WIDTH-1:0] vpos,
  output logic [2:0]            FB_RGB,
  input  logic                  paint_req,
  input  logic [HPOS_WIDTH-1:0] paint_x,
  input  logic [VPOS_WIDTH-1:0] paint_y,
  input  logic [2:0]            paint_color,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  done
);

  localparam int H_CELLS   = RESOLUTION_H >> SCALE_SHIFT;
  localparam int V_CELLS   = RESOLUTION_V >> SCALE_SHIFT;
  localparam int MEM_DEPTH = H_CELLS * V_CELLS;
  localparam int AW        = $clog2(MEM_DEPTH);

  // Two extra bits keep centre +/- brush free of wrap even when the canvas fills the coordinate range.
  localparam int XW = HPOS_WIDTH + 2;
  localparam int YW = VPOS_WIDTH + 2;
  localparam logic signed [XW-1:0] BRUSH_X = XW'(BRUSH_SIZE);
  localparam logic signed [YW-1:0] BRUSH_Y = YW'(BRUSH_SIZE);
  localparam logic signed [XW-1:0] MAX_X   = XW'(RESOLUTION_H - 1);
  localparam logic signed [YW-1:0] MAX_Y   = YW'(RESOLUTION_V - 1);

  localparam logic [AW-1:0]         LAST_ADDR = AW'(MEM_DEPTH - 1);
  localparam logic [HPOS_WIDTH:0]   LIM_H     = (HPOS_WIDTH+1)'(RESOLUTION_H);
  localparam logic [VPOS_WIDTH:0]   LIM_V     = (VPOS_WIDTH+1)'(RESOLUTION_V);

  state_t state_q, state_d;

  logic [AW-1:0]         clr_cnt;
  logic [HPOS_WIDTH-1:0] cx, x0, x1;
  logic [VPOS_WIDTH-1:0] cy, y1;
  logic [2:0]            color;

  logic signed [XW-1:0]  lo_x, hi_x;
  logic signed [YW-1:0]  lo_y, hi_y;
  logic [HPOS_WIDTH-1:0] x0_c, x1_c;
  logic [VPOS_WIDTH-1:0] y0_c, y1_c;

  logic          req_ok, rd_in, rd_ok;
  logic          clear_last, stamp_last;
  logic          we;
  logic [AW-1:0] waddr, raddr;
  logic [2:0]    wdata, rdata;

  // Brush bounds clamped to the canvas, then reduced to cell coordinates.
  always_comb begin
    lo_x = $signed({2'b00, paint_x}) - BRUSH_X;
    hi_x = $signed({2'b00, paint_x}) + BRUSH_X;
    lo_y = $signed({2'b00, paint_y}) - BRUSH_Y;
    hi_y = $signed({2'b00, paint_y}) + BRUSH_Y;
    if (lo_x[XW-1]) lo_x = '0;
    if (lo_y[YW-1]) lo_y = '0;
    if (hi_x > MAX_X) hi_x = MAX_X;
    if (hi_y > MAX_Y) hi_y = MAX_Y;
    x0_c = HPOS_WIDTH'(lo_x >>> SCALE_SHIFT);
    x1_c = HPOS_WIDTH'(hi_x >>> SCALE_SHIFT);
    y0_c = VPOS_WIDTH'(lo_y >>> SCALE_SHIFT);
    y1_c = VPOS_WIDTH'(hi_y >>> SCALE_SHIFT);
  end

  assign req_ok     = ({1'b0, paint_x} < LIM_H) && ({1'b0, paint_y} < LIM_V);
  assign clear_last = (clr_cnt == LAST_ADDR);
  assign stamp_last = (cx == x1) && (cy == y1);

  always_comb begin
    state_d = state_q;
    we      = 1'b0;
    waddr   = '0;
    wdata   = CLEAR_COLOR;
    unique case (state_q)
      CLEAR: begin
        we    = !reset;
        waddr = clr_cnt;
        if (clear_last) state_d = IDLE;
      end
      IDLE: begin
        if (clear_req)                state_d = CLEAR;
        else if (paint_req && req_ok) state_d = STAMP;
      end
      STAMP: begin
        we    = !reset;
        waddr = AW'(cell_addr(32'(cx), 32'(cy), H_CELLS));
        wdata = color;
        if (stamp_last) state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_cnt <= '0;
      done    <= 1'b0;
      rd_ok   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_ok   <= rd_in;
      done    <= (state_q == CLEAR && clear_last) || (state_q == STAMP && stamp_last);
      unique case (state_q)
        CLEAR: clr_cnt <= clear_last ? '0 : clr_cnt + 1'b1;
        IDLE: begin
          if (clear_req) begin
            clr_cnt <= '0;
          end else if (paint_req && req_ok) begin
            color <= paint_color;
            x0    <= x0_c;
            x1    <= x1_c;
            y1    <= y1_c;
            cx    <= x0_c;
            cy    <= y0_c;
          end
        end
        STAMP: begin
          if (cx == x1) begin
            cx <= x0;
            cy <= cy + 1'b1;
          end else begin
            cx <= cx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Off-canvas scan positions read cell 0 and are blanked one cycle later.
  assign rd_in = ({1'b0, hpos} < LIM_H) && ({1'b0, vpos} < LIM_V);
  assign raddr = rd_in ? AW'(cell_addr(32'(hpos >> SCALE_SHIFT), 32'(vpos >> SCALE_SHIFT), H_CELLS))
                       : '0;

  fb_ram #(
    .DEPTH (MEM_DEPTH),
    .ADDR_W(AW)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

  assign FB_RGB = rd_ok ? rdata : 3'b000;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_fb_paint_store.sv
// Directed bench for fb_paint_store: clear timing, stamp footprints, read latency/range, reset abort.
module tb_fb_paint_store;

  localparam int DEPTH = 19200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] hpos = '0, vpos = '0;
  logic [2:0] FB_RGB;
  logic       paint_req = 1'b0;
  logic [9:0] paint_x = '0, paint_y = '0;
  logic [2:0] paint_color = '0;
  logic       clear_req = 1'b0;
  logic       busy, done;

  int checks = 0;
  int errors = 0;

  fb_paint_store dut (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .FB_RGB     (FB_RGB),
    .paint_req  (paint_req),
    .paint_x    (paint_x),
    .paint_y    (paint_y),
    .paint_color(paint_color),
    .clear_req  (clear_req),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [9:0] x, input logic [9:0] y, input logic [2:0] exp);
    hpos = x;
    vpos = y;
    step();
    chk(tag, int'(FB_RGB), int'(exp));
  endtask

  // Counts busy/done samples over n cycles, starting with the sample just after the current edge.
  task automatic watch(input int n, output int nb, output int nd);
    nb = 0;
    nd = 0;
    repeat (n) begin
      if (busy === 1'b1) nb++;
      if (done === 1'b1) nd++;
      step();
    end
  endtask

  task automatic paint(input logic [9:0] x, input logic [9:0] y, input logic [2:0] c,
                       output int nb, output int nd);
    paint_x     = x;
    paint_y     = y;
    paint_color = c;
    paint_req   = 1'b1;
    step();
    paint_req   = 1'b0;
    watch(200, nb, nd);
  endtask

  initial begin
    int nb, nd;
    int bad;

    // Reset held three cycles.
    repeat (3) step();
    chk("reset_busy", int'(busy), 1);
    chk("reset_done", int'(done), 0);
    chk("reset_rgb", int'(FB_RGB), 0);

    reset = 1'b0;
    watch(DEPTH + 10, nb, nd);
    chk("init_clear_busy_cycles", nb, DEPTH);
    chk("init_clear_done_pulses", nd, 1);
    rd("clr_0_0", 10'd0, 10'd0, 3'b000);
    rd("clr_639_479", 10'd639, 10'd479, 3'b000);
    rd("clr_320_240", 10'd320, 10'd240, 3'b000);

    // Centre stamp: cells 75..85 x 55..65.
    paint(10'd320, 10'd240, 3'b101, nb, nd);
    chk("stamp1_busy_cycles", nb, 121);
    chk("stamp1_done_pulses", nd, 1);
    bad = 0;
    for (int y = 220; y <= 263; y++)
      for (int x = 300; x <= 343; x++) begin
        hpos = 10'(x);
        vpos = 10'(y);
        step();
        if (FB_RGB !== 3'b101) bad++;
      end
    chk("stamp1_region_bad_pixels", bad, 0);
    rd("stamp1_left_edge_out", 10'd299, 10'd240, 3'b000);
    rd("stamp1_right_edge_out", 10'd344, 10'd240, 3'b000);
    rd("stamp1_left_edge_in", 10'd300, 10'd240, 3'b101);
    rd("stamp1_top_out", 10'd320, 10'd219, 3'b000);
    rd("stamp1_bottom_out", 10'd320, 10'd264, 3'b000);

    // Corner stamp clamped at 0: cells 0..6 x 0..6.
    paint(10'd5, 10'd5, 3'b011, nb, nd);
    chk("stamp2_busy_cycles", nb, 49);
    chk("stamp2_done_pulses", nd, 1);
    rd("stamp2_0_0", 10'd0, 10'd0, 3'b011);
    rd("stamp2_27_27", 10'd27, 10'd27, 3'b011);
    rd("stamp2_28_0", 10'd28, 10'd0, 3'b000);
    rd("stamp2_0_28", 10'd0, 10'd28, 3'b000);

    // Latency: value appears exactly one cycle after the address.
    rd("lat_pre", 10'd0, 10'd479, 3'b000);
    hpos = 10'd320;
    vpos = 10'd240;
    #2;
    chk("lat_not_combinational", int'(FB_RGB), 0);
    step();
    chk("lat_one_cycle", int'(FB_RGB), 5);
    hpos = 10'd0;
    vpos = 10'd479;
    step();
    chk("lat_next_only", int'(FB_RGB), 0);

    // Off-canvas reads blank even where the wrapped cell would be painted.
    rd("range_h640", 10'd640, 10'd240, 3'b000);
    rd("range_v480", 10'd320, 10'd480, 3'b000);
    rd("range_back_in", 10'd320, 10'd240, 3'b101);

    // Off-canvas brush centre is dropped silently.
    paint(10'd700, 10'd100, 3'b111, nb, nd);
    chk("drop_x700_busy", nb, 0);
    chk("drop_x700_done", nd, 0);

    // Clear and paint together: clear wins; a paint mid-clear is ignored.
    paint_x     = 10'd100;
    paint_y     = 10'd100;
    paint_color = 3'b111;
    paint_req   = 1'b1;
    clear_req   = 1'b1;
    step();
    paint_req   = 1'b0;
    clear_req   = 1'b0;
    nb = 0;
    nd = 0;
    for (int i = 0; i < DEPTH + 10; i++) begin
      if (busy === 1'b1) nb++;
      if (done === 1'b1) nd++;
      paint_req = (i == 100);
      step();
    end
    paint_req = 1'b0;
    chk("clear_wins_busy_cycles", nb, DEPTH);
    chk("clear_wins_done_pulses", nd, 1);
    rd("cleared_320_240", 10'd320, 10'd240, 3'b000);
    rd("cleared_0_0", 10'd0, 10'd0, 3'b000);
    rd("cleared_100_100", 10'd100, 10'd100, 3'b000);

    // Reset partway through a stamp aborts it and reruns a full clear.
    paint_x     = 10'd320;
    paint_y     = 10'd240;
    paint_color = 3'b110;
    paint_req   = 1'b1;
    step();
    paint_req   = 1'b0;
    repeat (49) step();
    chk("midstamp_busy", int'(busy), 1);
    reset = 1'b1;
    step();
    chk("midstamp_reset_busy", int'(busy), 1);
    chk("midstamp_reset_done", int'(done), 0);
    reset = 1'b0;
    watch(DEPTH + 10, nb, nd);
    chk("reclear_busy_cycles", nb, DEPTH);
    chk("reclear_done_pulses", nd, 1);
    rd("reclear_300_220", 10'd300, 10'd220, 3'b000);
    rd("reclear_343_232", 10'd343, 10'd232, 3'b000);
    rd("reclear_320_240", 10'd320, 10'd240, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
